// File: rtl/aes_job_arbiter_pkg.sv
// rtl/aes_job_arbiter_pkg.sv - shared types and constants for the AES job arbiter
// Contents: requester count, default core timeout, arbiter FSM state encoding.
package aes_job_arbiter_pkg;

  localparam int NUM_REQ         = 2;
  localparam int DEFAULT_TIMEOUT = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_RESP       = 3'd3,
    ST_SCRUB      = 3'd4,
    ST_SCRUB_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/aes_job_arbiter_rr_arb2.sv
// rtl/aes_job_arbiter_rr_arb2.sv - two-way combinational round-robin grant
// Ports:
//   req_i         requests from the two requesters
//   last_grant_i  index of the requester served most recently
//   grant_valid_o at least one request is present
//   grant_idx_o   index of the winning requester
module rr_arb2
  import aes_job_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_grant_i,
  output logic               grant_valid_o,
  output logic               grant_idx_o
);

  // The requester that was not served last wins whenever it asks;
  // otherwise the last winner may go again.
  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = last_grant_i;
    if (req_i[~last_grant_i]) begin
      grant_idx_o = ~last_grant_i;
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// rtl/aes_job_arbiter.sv - shares one AES core between two requesters, scrubbing it after each job
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      job request / one-cycle accept pulse per requester
//   req_key/req_pt           128-bit operands, requester i on bits [128i+127:128i]
//   rsp_valid/rsp_ready      result handshake per requester
//   rsp_data/rsp_err         ciphertext (zero when not valid) / timeout flag
//   busy                     arbiter not idle
//   core_start/core_key/core_plaintext/core_ciphertext/core_done   shared core interface
module aes_job_arbiter
  import aes_job_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [128*NUM_REQ-1:0]   req_key,
  input  logic [128*NUM_REQ-1:0]   req_pt,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [127:0]             rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     core_start,
  output logic [127:0]             core_key,
  output logic [127:0]             core_plaintext,
  input  logic [127:0]             core_ciphertext,
  input  logic                     core_done
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  pt_q, pt_d;
  logic [127:0]  resp_q, resp_d;
  logic          err_q, err_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic grant_valid;
  logic grant_idx;
  logic timed_out;
  logic core_finished;

  rr_arb2 u_rr_arb2 (
    .req_i         (req_valid),
    .last_grant_i  (last_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // A done seen while cnt is still 0 may belong to the previous operation.
  assign timed_out     = (cnt_q == CNT_LAST);
  assign core_finished = (cnt_q != '0) && core_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      pt_q    <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    pt_d    = pt_q;
    resp_d  = resp_q;
    err_d   = err_q;
    owner_d = owner_q;
    last_d  = last_q;
    ready_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          ready_d = 1'b1;
          key_d   = grant_idx ? req_key[255:128] : req_key[127:0];
          pt_d    = grant_idx ? req_pt[255:128]  : req_pt[127:0];
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Operands are on the core bus this cycle; drop our copy right away.
        key_d   = '0;
        pt_d    = '0;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out) begin
          resp_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (core_finished) begin
          resp_d  = core_ciphertext;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          resp_d  = '0;
          err_d   = 1'b0;
          state_d = ST_SCRUB;
        end
      end
      ST_SCRUB: begin
        cnt_d   = '0;
        state_d = ST_SCRUB_WAIT;
      end
      ST_SCRUB_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out || core_finished) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while rst is asserted, not only after the reset edge.
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_data       = '0;
    rsp_err        = 1'b0;
    busy           = 1'b0;
    core_start     = 1'b0;
    core_key       = '0;
    core_plaintext = '0;
    if (!rst) begin
      busy = (state_q != ST_IDLE);
      if (ready_q) begin
        req_ready = owner_q ? 2'b10 : 2'b01;
      end
      case (state_q)
        ST_START: begin
          core_start     = 1'b1;
          core_key       = key_q;
          core_plaintext = pt_q;
        end
        ST_RESP: begin
          rsp_valid = owner_q ? 2'b10 : 2'b01;
          rsp_data  = resp_q;
          rsp_err   = err_q;
        end
        ST_SCRUB: core_start = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb/tb_aes_job_arbiter.sv - self-checking bench for aes_job_arbiter
module tb_aes_job_arbiter;

  localparam int T = 32;
  localparam logic [127:0] KEY_LIT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_LIT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_LIT  = 128'h00102030405060708090a0b0c0d0e0f0;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [255:0] req_key, req_pt;
  logic [127:0] rsp_data, core_key, core_plaintext, core_ciphertext;
  logic         rsp_err, busy, core_start, core_done;

  always #5 clk = ~clk;

  aes_job_arbiter #(.TIMEOUT(T)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_key         (req_key),
    .req_pt          (req_pt),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .core_start      (core_start),
    .core_key        (core_key),
    .core_plaintext  (core_plaintext),
    .core_ciphertext (core_ciphertext),
    .core_done       (core_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // requesters
  logic [1:0]   pend = 2'b00;
  logic [127:0] pkey [2];
  logic [127:0] ppt  [2];

  // stimulus controls
  int fix_d      = 12;
  int fix_ds     = 12;
  int rsp_pol    = 0;
  bit stale_next = 1'b0;
  bit auto_mode  = 1'b0;

  // job-level model: one record of absolute cycle stamps per job
  bit           job_active = 1'b0;
  bit           hs_done    = 1'b0;
  bit           last       = 1'b1;
  bit           j_owner    = 1'b0;
  bit           j_stale    = 1'b0;
  bit           r_err      = 1'b0;
  logic [127:0] j_key, j_pt, r_data;
  int           t_start, t_resp, t_hs, t_idle, d_job_at, d_scrub_at;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] aes_stub(input logic [127:0] k, input logic [127:0] p);
    return k ^ p;
  endfunction

  // 0 means the core never signals done
  function automatic int pick_delay(input int fixed);
    if (fixed >= 0) return fixed;
    case ($urandom_range(0, 9))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 5;
      5: return T - 1;
      6: return T;
      default: return 12;
    endcase
  endfunction

  function automatic int core_cycles(input int d);
    return (d >= 2 && d <= T - 1) ? d : T;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic issue(input int i, input logic [127:0] k, input logic [127:0] p);
    pend[i] = 1'b1;
    pkey[i] = k;
    ppt[i]  = p;
  endtask

  task automatic step();
    logic [1:0]   oh, e_ready, e_valid;
    logic [127:0] e_key, e_pt, e_data;
    logic         e_busy, e_start, in_resp;
    int           d;
    @(posedge clk);
    cyc++;
    #1;
    if (job_active && hs_done && cyc >= t_idle) begin
      job_active = 1'b0;
      last       = j_owner;
    end
    if (auto_mode) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 7) == 0) issue(i, rand128(), rand128());
    end
    req_valid = pend;
    req_key   = {pend[1] ? pkey[1] : rand128(), pend[0] ? pkey[0] : rand128()};
    req_pt    = {pend[1] ? ppt[1]  : rand128(), pend[0] ? ppt[0]  : rand128()};
    case (rsp_pol)
      0:       rsp_ready = 2'b11;
      1:       rsp_ready = 2'($urandom_range(0, 3));
      default: rsp_ready = (job_active && cyc >= t_resp && cyc < t_resp + 20) ? 2'b10 : 2'b11;
    endcase
    core_done = job_active && ((cyc == d_job_at) || (hs_done && cyc == d_scrub_at) ||
                               (j_stale && (cyc == t_start || cyc == t_start + 1)));
    core_ciphertext = (job_active && cyc == d_job_at) ? aes_stub(j_key, j_pt) : rand128();
    #1;

    oh      = j_owner ? 2'b10 : 2'b01;
    in_resp = job_active && cyc >= t_resp && (!hs_done || cyc <= t_hs);
    e_busy  = job_active;
    e_ready = (job_active && cyc == t_start) ? oh : 2'b00;
    e_start = job_active && (cyc == t_start || (hs_done && cyc == t_hs + 1));
    e_key   = (job_active && cyc == t_start) ? j_key : '0;
    e_pt    = (job_active && cyc == t_start) ? j_pt : '0;
    e_valid = in_resp ? oh : 2'b00;
    e_data  = in_resp ? r_data : '0;
    if (rst) begin
      e_busy = 0; e_ready = 0; e_start = 0; e_key = 0; e_pt = 0; e_valid = 0; e_data = 0;
    end
    check("busy", busy, e_busy);
    check("req_ready", req_ready, e_ready);
    check("core_start", core_start, e_start);
    check("core_key", core_key, e_key);
    check("core_plaintext", core_plaintext, e_pt);
    check("rsp_valid", rsp_valid, e_valid);
    check("rsp_data", rsp_data, e_data);
    if (e_valid != 0) check("rsp_err", rsp_err, r_err);

    if (rst) begin
      job_active = 1'b0;
      hs_done    = 1'b0;
      last       = 1'b1;
    end else if (!job_active) begin
      if (req_valid != 2'b00) begin
        j_owner  = req_valid[!last] ? !last : last;
        j_key    = pkey[j_owner];
        j_pt     = ppt[j_owner];
        t_start  = cyc + 1;
        d        = pick_delay(fix_d);
        d_job_at = (d == 0) ? -1 : t_start + d;
        if (d >= 2 && d <= T - 1) begin
          t_resp = t_start + d + 1;
          r_data = aes_stub(j_key, j_pt);
          r_err  = 1'b0;
        end else begin
          t_resp = t_start + T + 1;
          r_data = '0;
          r_err  = 1'b1;
        end
        j_stale    = auto_mode ? ($urandom_range(0, 3) == 0) : stale_next;
        hs_done    = 1'b0;
        job_active = 1'b1;
      end
    end else begin
      if (cyc == t_start) pend[j_owner] = 1'b0;
      if (!hs_done && cyc >= t_resp && rsp_ready[j_owner]) begin
        hs_done    = 1'b1;
        t_hs       = cyc;
        d          = pick_delay(fix_ds);
        d_scrub_at = (d == 0) ? -1 : t_hs + 1 + d;
        t_idle     = t_hs + 1 + core_cycles(d) + 1;
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_key = 0; req_pt = 0; rsp_ready = 0;
    core_done = 0; core_ciphertext = 0;
    run_to(3);
    rst = 1'b0;

    // single job from reset
    issue(0, KEY_LIT, PT_LIT);
    run_to(5);
    check("lit_req_ready", req_ready, 2'b01);
    check("lit_core_key", core_key, KEY_LIT);
    check("lit_core_pt", core_plaintext, PT_LIT);
    run_to(17);
    check("lit_rsp_early", rsp_valid, 2'b00);
    run_to(18);
    check("lit_rsp_valid", rsp_valid, 2'b01);
    check("lit_rsp_data", rsp_data, CT_LIT);
    check("lit_rsp_err", rsp_err, 1'b0);
    run_to(19);
    check("lit_scrub_start", core_start, 1'b1);
    check("lit_scrub_key", core_key, 128'h0);
    run_to(31);
    check("lit_busy_scrub", busy, 1'b1);
    run_to(32);
    check("lit_idle", busy, 1'b0);

    // contention right after reset
    rst = 1'b1;
    run_to(34);
    rst = 1'b0;
    issue(0, rand128(), rand128());
    issue(1, rand128(), rand128());
    run_to(36);
    check("lit_contend_first", req_ready, 2'b01);
    run_to(50);
    check("lit_scrub_pt", {core_start, core_plaintext}, {1'b1, 128'h0});
    run_to(64);
    check("lit_contend_second", req_ready, 2'b10);
    run_to(95);

    // backpressure with the wrong ready bit raised
    rsp_pol = 2;
    issue(0, KEY_LIT, PT_LIT);
    run_to(129);
    check("lit_bp_valid", rsp_valid, 2'b01);
    check("lit_bp_data", rsp_data, CT_LIT);
    run_to(146);

    // timeout with no done, then done landing on the timeout cycle
    rsp_pol = 0;
    fix_d   = 0;
    issue(1, rand128(), rand128());
    run_to(180);
    check("lit_to_early", rsp_valid, 2'b00);
    run_to(181);
    check("lit_to_valid", rsp_valid, 2'b10);
    check("lit_to_data", rsp_data, 128'h0);
    check("lit_to_err", rsp_err, 1'b1);
    run_to(200);
    fix_d = T;
    issue(0, rand128(), rand128());
    run_to(235);
    check("lit_to_prio_err", {rsp_valid, rsp_err}, {2'b01, 1'b1});
    run_to(252);

    // stale done held across START
    fix_d      = 12;
    stale_next = 1'b1;
    issue(1, rand128(), rand128());
    run_to(255);
    check("lit_stale_ignored", rsp_valid, 2'b00);
    run_to(267);
    check("lit_stale_valid", {rsp_valid, rsp_err}, {2'b10, 1'b0});
    run_to(285);
    stale_next = 1'b0;

    // reset while waiting at cnt=5
    issue(1, rand128(), rand128());
    step();
    run_to(t_start + 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(0, rand128(), rand128());
    issue(1, rand128(), rand128());
    step();
    check("lit_rst_idle", {busy, rsp_valid, core_start}, 4'b0);
    step();
    check("lit_rst_regrant", req_ready, 2'b01);
    run_to(cyc + 70);

    // randomized traffic
    auto_mode = 1'b1;
    fix_d     = -1;
    fix_ds    = -1;
    rsp_pol   = 1;
    run_to(cyc + 3000);
    auto_mode = 1'b0;
    rst       = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
